// File: rtl/status_reg_stack.sv
// status_reg_stack: status word with per-bit masked software writes, an
// independent ALU flag path and a LIFO shadow stack for interrupt entry/return.
// Sticky error bits flag stack overflow, underflow and push/pop collisions.
module status_reg_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic [WIDTH-1:0] SRSet,
    input  logic             flag_en,
    input  logic [WIDTH-1:0] flag_mask,
    input  logic [WIDTH-1:0] flag_data,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic [WIDTH-1:0] SRData,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty,
    output logic             ovf_err,
    output logic             unf_err,
    output logic             col_err
);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] w_bits;
    logic [WIDTH-1:0] f_bits;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] top;
    logic             collide;
    logic             pop_ok;
    logic             pop_bad;
    logic             push_ok;
    logic             push_bad;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Software write owns its masked bits; the ALU only touches what is left.
    always_comb begin
        w_bits = wr_en ? wr_mask : '0;
        f_bits = flag_en ? (flag_mask & ~w_bits) : '0;
        merged = (SRData & ~w_bits & ~f_bits) | (SRSet & w_bits) | (flag_data & f_bits);
    end

    // Decode the request into one of the mutually exclusive stack actions.
    always_comb begin
        collide  = push & pop;
        pop_ok   = pop & ~push & ~empty;
        pop_bad  = pop & ~push & empty;
        push_ok  = push & ~pop & ~full;
        push_bad = push & ~pop & full;
    end

    // Read the entry at level-1 as a mux so the index never leaves the array.
    always_comb begin
        top = stack[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (LW'(i + 1) == level) top = stack[i];
        end
    end

    // Stack storage carries no reset; entries above level are never read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (LW'(i) == level) stack[i] <= SRData;
            end
        end
    end

    // Status word, stack pointer and sticky error bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SRData  <= RST_VAL;
            level   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
            col_err <= 1'b0;
        end else begin
            if (pop_ok) begin
                SRData <= top;
                level  <= level - LW'(1);
            end else if (!collide && !pop_bad) begin
                SRData <= merged;
                if (push_ok) level <= level + LW'(1);
            end
            // A new error event in the same cycle as err_clr keeps the bit set.
            ovf_err <= (ovf_err & ~err_clr) | push_bad;
            unf_err <= (unf_err & ~err_clr) | pop_bad;
            col_err <= (col_err & ~err_clr) | collide;
        end
    end

endmodule

// File: tb/tb_status_reg_stack.sv
module tb_status_reg_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_mask;
    logic [7:0] SRSet;
    logic       flag_en;
    logic [7:0] flag_mask;
    logic [7:0] flag_data;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [7:0] SRData;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       ovf_err;
    logic       unf_err;
    logic       col_err;

    int total = 0;
    int bad   = 0;

    status_reg_stack #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_mask(wr_mask), .SRSet(SRSet),
        .flag_en(flag_en), .flag_mask(flag_mask), .flag_data(flag_data),
        .push(push), .pop(pop), .err_clr(err_clr),
        .SRData(SRData), .level(level), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err), .col_err(col_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en = 0; wr_mask = 0; SRSet = 0;
        flag_en = 0; flag_mask = 0; flag_data = 0;
        push = 0; pop = 0; err_clr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input logic [7:0] m, input logic [7:0] d);
        wr_en = 1; wr_mask = m; SRSet = d;
    endtask

    initial begin
        idle();
        rst = 1;
        #7 rst = 0;
        chk("rst_sr", SRData, 8'h00);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_errs", {ovf_err, unf_err, col_err}, 3'b000);

        // masked writes
        wr(8'h0F, 8'hAB); cyc();
        chk("mask_lo", SRData, 8'h0B);
        wr(8'hF0, 8'h5C); cyc();
        chk("mask_hi", SRData, 8'h5B);

        // write/flag overlap
        wr(8'hFF, 8'h00); cyc();
        wr(8'h03, 8'h01);
        flag_en = 1; flag_mask = 8'h06; flag_data = 8'h06; cyc();
        chk("overlap", SRData, 8'h05);
        flag_en = 1; flag_mask = 8'hC0; flag_data = 8'h80; cyc();
        chk("flag_only", SRData, 8'h85);
        cyc();
        chk("hold", SRData, 8'h85);

        // push/pop round trip
        wr(8'hFF, 8'h11); cyc();
        wr(8'hFF, 8'h22); push = 1; cyc();
        chk("rt_push_sr", SRData, 8'h22);
        chk("rt_push_lvl", level, 3'd1);
        chk("rt_push_empty", empty, 1'b0);
        wr(8'hFF, 8'h99); pop = 1; cyc();
        chk("rt_pop_sr", SRData, 8'h11);
        chk("rt_pop_lvl", level, 3'd0);
        chk("rt_pop_empty", empty, 1'b1);

        // overflow
        for (int i = 1; i <= 5; i++) begin
            wr(8'hFF, 8'(i)); cyc();
            push = 1; cyc();
            if (i == 4) begin
                chk("ovf_lvl4", level, 3'd4);
                chk("ovf_full4", full, 1'b1);
                chk("ovf_err_pre", ovf_err, 1'b0);
            end
        end
        chk("ovf_lvl", level, 3'd4);
        chk("ovf_full", full, 1'b1);
        chk("ovf_err", ovf_err, 1'b1);
        chk("ovf_sr", SRData, 8'h05);
        for (int i = 4; i >= 1; i--) begin
            pop = 1; cyc();
            chk($sformatf("pop_%0d", i), SRData, 8'(i));
            chk($sformatf("pop_lvl_%0d", i), level, 3'(i - 1));
        end
        chk("pop_empty", empty, 1'b1);
        chk("pop_full", full, 1'b0);

        // underflow and collision
        pop = 1; wr(8'hFF, 8'hEE); cyc();
        chk("unf_sr", SRData, 8'h01);
        chk("unf_err", unf_err, 1'b1);
        chk("unf_lvl", level, 3'd0);
        push = 1; pop = 1; wr(8'hFF, 8'h77); cyc();
        chk("col_sr", SRData, 8'h01);
        chk("col_lvl", level, 3'd0);
        chk("col_err", col_err, 1'b1);
        err_clr = 1; cyc();
        chk("clr_errs", {ovf_err, unf_err, col_err}, 3'b000);
        err_clr = 1; pop = 1; cyc();
        chk("clr_vs_set", {ovf_err, unf_err, col_err}, 3'b010);

        // async reset mid-stack
        wr(8'hFF, 8'h0A); cyc();
        push = 1; cyc();
        push = 1; cyc();
        push = 1; wr(8'hFF, 8'h3C); cyc();
        chk("pre_rst_lvl", level, 3'd3);
        chk("pre_rst_sr", SRData, 8'h3C);
        rst = 1;
        #2;
        chk("arst_lvl", level, 3'd0);
        chk("arst_sr", SRData, 8'h00);
        chk("arst_empty", empty, 1'b1);
        chk("arst_unf", unf_err, 1'b0);
        #1 rst = 0;
        pop = 1; cyc();
        chk("post_rst_unf", unf_err, 1'b1);
        chk("post_rst_sr", SRData, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
